// File: rtl/rx_fifo_pkg.sv
// Shared state encoding and defaults for the UART-to-FIFO frame loader.
package rx_fifo_pkg;

   typedef enum logic [3:0] {
      ST_LOAD  = 4'b0001,
      ST_DRAIN = 4'b0010,
      ST_FLUSH = 4'b0100,
      ST_DONE  = 4'b1000
   } state_t;

   localparam int         FRAME_LEN_DEF     = 256;
   localparam logic [7:0] PATTERN_START_DEF = 8'h00;

   // Byte idx of a frame is expected to be start + idx, wrapping at 8 bits.
   function automatic logic [7:0] expected_byte(input logic [7:0] start, input logic [7:0] idx);
      return start + idx;
   endfunction

endpackage

// File: rtl/rx_fifo_frame_loader_pattern_checker.sv
// Compares each read-back byte against the incrementing pattern; saturating mismatch count.
// Latency: chk_idx/err_cnt update on the edge that samples valid.
// Backpressure: none, one byte accepted per valid cycle.
module pattern_checker
   import rx_fifo_pkg::*;
#(
   parameter logic [7:0] PATTERN_START = PATTERN_START_DEF,
   parameter int         CNT_W         = 9
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             clr,
   input  logic             valid,
   input  logic [7:0]       data,
   output logic [CNT_W-1:0] chk_idx,
   output logic [15:0]      err_cnt
);

   logic mismatch;

   assign mismatch = (data != expected_byte(PATTERN_START, 8'(chk_idx)));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         chk_idx <= '0;
         err_cnt <= '0;
      end else if (clr) begin
         chk_idx <= '0;
         err_cnt <= '0;
      end else if (valid) begin
         chk_idx <= chk_idx + 1'b1;
         if (mismatch && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/rx_fifo_frame_loader.sv
// Loads a frame of UART bytes into the FIFO, drains it to a debug stream and checks the pattern.
// Latency: uart_done -> fifo_wr_en 1 cycle; fifo_rd_en -> out_valid 2 cycles.
// Backpressure: fifo_full drops the byte (ovf_err); fifo_empty stalls the drain without error.
module rx_fifo_frame_loader
   import rx_fifo_pkg::*;
#(
   parameter int         FRAME_LEN     = FRAME_LEN_DEF,
   parameter logic [7:0] PATTERN_START = PATTERN_START_DEF,
   parameter int         CNT_W         = 9
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        uart_done,
   input  logic [7:0]  uart_dout,
   input  logic        restart,
   input  logic        fifo_full,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_rd_data,
   output logic        fifo_wr_en,
   output logic [7:0]  fifo_wr_data,
   output logic        fifo_rd_en,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        frame_done,
   output logic        ovf_err,
   output logic        rx_drop,
   output logic [15:0] err_cnt
);

   localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

   state_t           state;
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] chk_idx;
   logic             rd_pend;
   logic             clr;

   assign fifo_rd_en = (state == ST_DRAIN) && !fifo_empty && (rd_cnt < FRAME_LEN_C);
   assign frame_done = (state == ST_DONE);
   assign clr        = (state == ST_DONE) && restart;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state        <= ST_LOAD;
         wr_cnt       <= '0;
         rd_cnt       <= '0;
         rd_pend      <= 1'b0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         ovf_err      <= 1'b0;
         rx_drop      <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;
         // rd_data is valid the cycle after rd_en, so the read is staged once before out_valid
         rd_pend    <= fifo_rd_en;
         out_valid  <= rd_pend;
         if (rd_pend)
            out_data <= fifo_rd_data;
         if (fifo_rd_en)
            rd_cnt <= rd_cnt + 1'b1;
         if (uart_done && ((state != ST_LOAD) || (wr_cnt == FRAME_LEN_C)))
            rx_drop <= 1'b1;

         case (state)
            ST_LOAD: begin
               if (uart_done && (wr_cnt != FRAME_LEN_C)) begin
                  if (fifo_full) begin
                     ovf_err <= 1'b1;
                  end else begin
                     fifo_wr_en   <= 1'b1;
                     fifo_wr_data <= uart_dout;
                     wr_cnt       <= wr_cnt + 1'b1;
                  end
               end
               if (wr_cnt == FRAME_LEN_C)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (rd_cnt == FRAME_LEN_C)
                  state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (chk_idx == FRAME_LEN_C)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               // restart clears after any same-cycle drop, so rx_drop ends at 0
               if (restart) begin
                  state   <= ST_LOAD;
                  wr_cnt  <= '0;
                  rd_cnt  <= '0;
                  ovf_err <= 1'b0;
                  rx_drop <= 1'b0;
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   pattern_checker #(
      .PATTERN_START(PATTERN_START),
      .CNT_W        (CNT_W)
   ) u_checker (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .clr    (clr),
      .valid  (out_valid),
      .data   (out_data),
      .chk_idx(chk_idx),
      .err_cnt(err_cnt)
   );

endmodule

// File: tb/tb_rx_fifo_frame_loader.sv
// Bench: random-gap UART frames through a 256x8 FIFO model; scoreboard checks the read-back stream.
module tb_rx_fifo_frame_loader;

   localparam int         FL = 256;
   localparam logic [7:0] PS = 8'h00;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        uart_done = 1'b0;
   logic [7:0]  uart_dout = 8'h00;
   logic        restart = 1'b0;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_rd_data;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        fifo_rd_en;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        frame_done;
   logic        ovf_err;
   logic        rx_drop;
   logic [15:0] err_cnt;

   int         tests = 0;
   int         fails = 0;
   int         wr_seen = 0;
   int         rd_seen = 0;
   int         out_seen = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   logic       force_full = 1'b0;
   logic       stall_empty = 1'b0;

   logic [7:0] fmem [256];
   int         fcnt, frp, fwp;

   rx_fifo_frame_loader dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .uart_done   (uart_done),
      .uart_dout   (uart_dout),
      .restart     (restart),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .fifo_rd_data(fifo_rd_data),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .fifo_rd_en  (fifo_rd_en),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .frame_done  (frame_done),
      .ovf_err     (ovf_err),
      .rx_drop     (rx_drop),
      .err_cnt     (err_cnt)
   );

   initial forever #5 sys_clk = ~sys_clk;

   // Standard-mode FIFO: read data appears the cycle after rd_en is sampled.
   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         fcnt <= 0; frp <= 0; fwp <= 0; fifo_rd_data <= 8'h00;
      end else begin
         if (fifo_wr_en && fcnt < 256) begin
            fmem[fwp] <= fifo_wr_data;
            fwp <= (fwp + 1) % 256;
         end
         if (fifo_rd_en && fcnt > 0) begin
            fifo_rd_data <= fmem[frp];
            frp <= (frp + 1) % 256;
         end
         fcnt <= fcnt + ((fifo_wr_en && fcnt < 256) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
      end
   end
   assign fifo_empty = (fcnt == 0) || stall_empty;
   assign fifo_full  = (fcnt >= 256) || force_full;

   always @(negedge sys_clk) begin
      #2;
      if (!sys_rst) begin
         if (fifo_wr_en) wr_seen++;
         if (fifo_rd_en) rd_seen++;
         if (fifo_wr_en || fifo_rd_en) begin
            tests++;
            if (fifo_wr_en && fifo_rd_en) begin
               fails++;
               $display("FAIL wr_rd_overlap: wr_en=%0b rd_en=%0b, required not both high", fifo_wr_en, fifo_rd_en);
            end
         end
         if (out_valid) begin
            out_seen++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL out_unexpected: out_data=%02h with no byte expected", out_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (out_data !== mon_exp) begin
                  fails++;
                  $display("FAIL out_data: got %02h expected %02h", out_data, mon_exp);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_valid"},  32'(out_valid),  0);
      check({tag, "_out_data"},   32'(out_data),   0);
      check({tag, "_wr_en"},      32'(fifo_wr_en), 0);
      check({tag, "_rd_en"},      32'(fifo_rd_en), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_err_cnt"},    32'(err_cnt),    0);
      check({tag, "_ovf_err"},    32'(ovf_err),    0);
      check({tag, "_rx_drop"},    32'(rx_drop),    0);
   endtask

   task automatic do_restart(input bit with_byte);
      @(negedge sys_clk);
      restart = 1'b1;
      if (with_byte) begin uart_done = 1'b1; uart_dout = 8'h3C; end
      @(negedge sys_clk);
      restart = 1'b0; uart_done = 1'b0;
      #1;
      check("restart_frame_done", 32'(frame_done), 0);
      check("restart_err_cnt",    32'(err_cnt),    0);
      check("restart_rx_drop",    32'(rx_drop),    0);
      check("restart_ovf_err",    32'(ovf_err),    0);
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic run_frame(input int bad_idx, input int full_idx, input int stall_at,
                            input int rst_at, input bit rnd);
      int acc, pulses, nerr, base_wr, base_rd, base_out, cyc, stall_left;
      bit stalled, ovf_exp;
      logic [7:0] b;
      acc = 0; pulses = 0; nerr = 0; cyc = 0; stall_left = 0; stalled = 0; ovf_exp = 0;
      base_wr = wr_seen; base_rd = rd_seen; base_out = out_seen;
      while (acc < FL && pulses < FL + 8) begin
         b = PS + 8'(acc);
         if (acc == bad_idx) b = 8'hAA;
         if (rnd && $urandom_range(0, 15) == 0) b = 8'($urandom);
         @(negedge sys_clk);
         force_full = (pulses == full_idx);
         uart_done = 1'b1; uart_dout = b;
         if (pulses == full_idx) ovf_exp = 1'b1;
         else begin
            exp_q.push_back(b);
            if (b != PS + 8'(acc)) nerr++;
            acc++;
         end
         pulses++;
         @(negedge sys_clk);
         uart_done = 1'b0; force_full = 1'b0;
         repeat ($urandom_range(3, 6)) @(negedge sys_clk);
      end
      while (!frame_done && cyc < 6000) begin
         @(negedge sys_clk);
         cyc++;
         if (stall_at >= 0 && !stalled && rd_seen - base_rd >= stall_at) begin
            stalled = 1'b1; stall_left = 10; stall_empty = 1'b1;
         end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) stall_empty = 1'b0;
         end
         #1;
         if (stall_empty) check("stall_rd_en", 32'(fifo_rd_en), 0);
         if (rst_at >= 0 && rd_seen - base_rd >= rst_at) begin
            sys_rst = 1'b1;
            #1;
            check_all_zero("midrst");
            exp_q.delete();
            stall_empty = 1'b0;
            repeat (2) @(negedge sys_clk);
            sys_rst = 1'b0;
            return;
         end
      end
      check("frame_done", 32'(frame_done), 1);
      check("err_cnt", 32'(err_cnt), 32'(nerr));
      check("ovf_err", 32'(ovf_err), 32'(ovf_exp));
      check("rx_drop", 32'(rx_drop), 0);
      check("wr_count", 32'(wr_seen - base_wr), FL);
      check("rd_count", 32'(rd_seen - base_rd), FL);
      check("out_count", 32'(out_seen - base_out), FL);
      check("exp_left", 32'(exp_q.size()), 0);
   endtask

   initial begin
      int base;
      sys_rst = 1'b0;
      #1 sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      #1 check_all_zero("reset");
      @(negedge sys_clk);
      sys_rst = 1'b0;

      run_frame(-1, -1, -1, -1, 1'b0);

      base = wr_seen;
      @(negedge sys_clk);
      uart_done = 1'b1; uart_dout = 8'h55;
      @(negedge sys_clk);
      uart_done = 1'b0;
      #1;
      check("late_rx_drop", 32'(rx_drop), 1);
      check("late_frame_done", 32'(frame_done), 1);
      repeat (4) @(negedge sys_clk);
      check("late_no_write", 32'(wr_seen - base), 0);
      do_restart(1'b1);

      run_frame(17, -1, -1, -1, 1'b0);
      do_restart(1'b0);
      run_frame(-1, 5, -1, -1, 1'b0);
      do_restart(1'b0);
      run_frame(-1, -1, 100, -1, 1'b0);
      do_restart(1'b0);
      run_frame(-1, -1, -1, 100, 1'b0);
      run_frame(-1, -1, -1, -1, 1'b0);
      do_restart(1'b0);
      run_frame(-1, -1, $urandom_range(20, 200), -1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rx_fifo_frame_loader.md
Name: rx_fifo_frame_loader

Overview:
- Sits between uart_rx and the 256x8 FIFO IP in the loopback test design.
- LOAD phase: writes each received UART byte into the FIFO until FRAME_LEN bytes are stored.
- DRAIN phase: reads the whole frame back, presents each byte on a registered debug/ILA stream and checks it against the expected incrementing pattern.
- Then holds a done/status summary until restarted.

Parameters:
- FRAME_LEN, 256, bytes per frame (2..256).
- PATTERN_START, 8'h00, expected value of byte 0. Byte i is expected to equal (PATTERN_START + i) mod 256.
- CNT_W, 9, counter width; must be at least clog2(FRAME_LEN+1).

Ports:
- sys_clk  in  1  single clock for the block.
- sys_rst  in  1  asynchronous, active-high reset.
- uart_done  in  1  one-cycle pulse from uart_rx; byte valid. Pulses are at least 4 cycles apart.
- uart_dout  in  8  received byte, valid with uart_done.
- restart  in  1  one-cycle pulse; DONE -> LOAD.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  8  FIFO dout, standard mode: valid the cycle after rd_en is sampled high.
- fifo_wr_en  out  1  registered FIFO write enable.
- fifo_wr_data  out  8  registered FIFO write data.
- fifo_rd_en  out  1  combinational FIFO read enable.
- out_valid  out  1  registered; read-back byte valid.
- out_data  out  8  registered read-back byte.
- frame_done  out  1  high while in DONE.
- ovf_err  out  1  sticky; a byte was dropped because the FIFO was full.
- rx_drop  out  1  sticky; uart_done arrived outside LOAD.
- err_cnt  out  16  saturating count of pattern mismatches.

Behaviour:
- Reset (async, sys_rst=1): state=LOAD, all outputs 0, wr_cnt=rd_cnt=chk_idx=0. Applies mid-operation with no drain of the FIFO; the FIFO is reset by its owner.
- FSM states: LOAD, DRAIN, FLUSH, DONE.
- LOAD:
  - On uart_done with fifo_full=0: next cycle fifo_wr_en=1 for exactly 1 cycle, fifo_wr_data=uart_dout, wr_cnt+1.
  - On uart_done with fifo_full=1: no write, ovf_err set, wr_cnt unchanged.
  - Transition: on the cycle the write making wr_cnt==FRAME_LEN is issued, go to DRAIN on the next edge.
- DRAIN:
  - fifo_rd_en = (state==DRAIN) && !fifo_empty && (rd_cnt < FRAME_LEN). rd_cnt increments on each cycle rd_en is high.
  - If fifo_empty=1, rd_en stays 0 (stall, no error); rd_cnt resumes when empty drops.
  - One cycle after rd_en: fifo_rd_data is captured. Next edge: out_valid=1, out_data=that byte. Total rd_en -> out_valid latency is 2 cycles.
  - Back-to-back reads give back-to-back out_valid.
  - When rd_cnt reaches FRAME_LEN, go to FLUSH.
- FLUSH: waits until the last out_valid has been produced (at most 2 cycles), then goes to DONE.
- Checker: on each out_valid, compare out_data to PATTERN_START+chk_idx (8-bit wrap). On mismatch, err_cnt+1, saturating at 16'hFFFF. chk_idx then increments.
- DONE:
  - frame_done=1. Status outputs hold.
  - restart: go to LOAD; clear wr_cnt, rd_cnt, chk_idx, err_cnt, ovf_err, rx_drop; frame_done drops on the next edge.
  - restart in any other state is ignored.
- uart_done in DRAIN, FLUSH or DONE: byte discarded, rx_drop set, no FIFO write.
- Simultaneous uart_done and restart in DONE: restart wins, the byte is discarded and counted as rx_drop before the clear. The clear takes priority, so rx_drop ends at 0.
- fifo_wr_en and fifo_rd_en are never high in the same cycle.

Decomposition:
- Shared package, rx_fifo_pkg:
  - state encoding, one-hot 4-bit: LOAD=4'b0001, DRAIN=4'b0010, FLUSH=4'b0100, DONE=4'b1000.
  - FRAME_LEN default.
  - PATTERN_START default.
- Sub-module: pattern_checker. Inputs: valid and data. Outputs: the chk_idx counter and the saturating err_cnt. Instantiated once.
- The FSM and FIFO handshakes stay in the top.

Test Plan:
1. Happy path:
   - Stimulus: 256 uart_done pulses carrying 0x00..0xFF into an empty FIFO model.
   - Response: 256 fifo_wr_en pulses, then DRAIN; 256 out_valid with out_data 0x00..0xFF in order; err_cnt=0; frame_done=1; ovf_err=0.
2. Corrupt byte:
   - Stimulus: bytes 0..255, but byte 17 sent as 0xAA.
   - Response: out_data[17]=0xAA; err_cnt=1 at DONE.
3. Full FIFO:
   - Stimulus: force fifo_full=1 during byte 5.
   - Response: no write for byte 5, ovf_err=1, wr_cnt stays at 5; the frame completes after 257 pulses.
4. Empty stall:
   - Stimulus: FIFO model holds fifo_empty=1 for 10 cycles mid-drain.
   - Response: rd_en=0 for those cycles; output order preserved; err_cnt=0; total out_valid count=256.
5. Late byte and restart:
   - Stimulus: uart_done arrives in DONE.
   - Response: rx_drop=1, no fifo_wr_en.
   - Then pulse restart. Response: state LOAD, err_cnt=0, rx_drop=0, frame_done=0.
6. Async reset mid-DRAIN:
   - Stimulus: sys_rst at rd_cnt=100.
   - Response: all outputs 0 immediately; state LOAD; the next frame of 256 bytes completes normally.
